// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode constants, register indices, NOP word and write-back FSM encoding
package cpu_defs;
    localparam logic [4:0] OP_ADDSP3 = 5'b00000;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_SP     = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_MOVE   = 5'b01111;
    localparam logic [4:0] OP_LW_SP  = 5'b10010;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW_SP  = 5'b11010;
    localparam logic [4:0] OP_SW     = 5'b11011;
    localparam logic [4:0] OP_RRR    = 5'b11100;
    localparam logic [4:0] OP_ALU    = 5'b11101;
    localparam logic [4:0] OP_IH     = 5'b11110;
    localparam logic [3:0] REG_SP = 4'd8;
    localparam logic [3:0] REG_IH = 4'd9;
    localparam logic [15:0] NOP = 16'h0800;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} wb_state_t;
    function automatic logic is_load_op(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_LW_SP);
    endfunction
    function automatic logic is_store_op(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_SW_SP);
    endfunction
endpackage

// File: rtl/wb_dest_decode.sv
// wb_dest_decode: instruction word -> register-file write enable/address and load/store class
//   instr_i    in  16  instruction word, opcode in [15:11]
//   wr_en_o    out 1   instruction writes the register file
//   waddr_o    out 4   destination (0-7 R0-R7, 8 SP, 9 IH)
//   is_load_o  out 1   lw / lw_sp
//   is_store_o out 1   sw / sw_sp
module wb_dest_decode
    import cpu_defs::*;
(
    input  logic [15:0] instr_i,
    output logic        wr_en_o,
    output logic [3:0]  waddr_o,
    output logic        is_load_o,
    output logic        is_store_o
);
    logic [4:0] op;
    logic       alu_wr, sp_wr, rx_wr, ry_wr, rz_wr, ih_wr;
    always_comb begin
        op = instr_i[15:11];
        // 11101 group: and/or/srlv/srav by funct, mfpc is funct 0 with sub-op 010
        alu_wr = (op == OP_ALU) && ((instr_i[4:0] inside {5'b01100, 5'b01101, 5'b00110, 5'b00111})
                 || (instr_i[7:0] == 8'b010_00000));
        // 01100 group: only addsp (011) and mtsp (100) write SP
        sp_wr = (op == OP_SP) && (instr_i[10:8] inside {3'b011, 3'b100});
        rx_wr = (op inside {OP_ADDSP3, OP_SHIFT, OP_ADDIU, OP_LI, OP_MOVE, OP_LW_SP}) || alu_wr
                || ((op == OP_IH) && !instr_i[0]);
        ry_wr = op inside {OP_ADDIU3, OP_LW};
        rz_wr = op == OP_RRR;
        ih_wr = (op == OP_IH) && instr_i[0];
        wr_en_o = rx_wr || ry_wr || rz_wr || sp_wr || ih_wr;
        waddr_o = ry_wr ? {1'b0, instr_i[7:5]} : rz_wr ? {1'b0, instr_i[4:2]} :
                  sp_wr ? REG_SP : ih_wr ? REG_IH : {1'b0, instr_i[10:8]};
        is_load_o = is_load_op(op);
        is_store_o = is_store_op(op);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access + write-back stage of the 16-bit CPU pipeline
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYC = 15
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_res,
  input  logic [15:0] ex_store_data,
  input  logic [15:0] ex_instruction,
  input  logic        ex_t_written,
  input  logic        ex_t,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        t_we,
  output logic        t_val,
  output logic        bus_err
);
  wb_state_t   state_q, state_d;
  logic        valid_q, valid_d, tw_q, tw_d, t_q, t_d;
  logic [15:0] res_q, res_d, sd_q, sd_d, instr_q, instr_d;
  logic        capture, access, timeout;
  logic        dec_wr, dec_ld, dec_st;
  logic [3:0]  dec_waddr;

  wb_dest_decode u_dec (
    .instr_i   (instr_q),
    .wr_en_o   (dec_wr),
    .waddr_o   (dec_waddr),
    .is_load_o (dec_ld),
    .is_store_o(dec_st)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      instr_q <= NOP;
      res_q   <= '0;
      sd_q    <= '0;
      tw_q    <= 1'b1;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      res_q   <= res_d;
      sd_q    <= sd_d;
      tw_q    <= tw_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    capture = !stall;
    valid_d = capture ? ex_valid : valid_q;
    instr_d = capture ? (ex_valid ? ex_instruction : NOP) : instr_q;
    res_d   = capture ? (ex_valid ? ex_res : '0) : res_q;
    sd_d    = capture ? (ex_valid ? ex_store_data : '0) : sd_q;
    tw_d    = capture ? (!ex_valid || ex_t_written) : tw_q;
    t_d     = capture ? (ex_valid && ex_t) : t_q;
    state_d = capture ? ((ex_valid && (is_load_op(ex_instruction[15:11]) || is_store_op(ex_instruction[15:11])))
              ? ST_ACCESS : ST_IDLE) : state_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d = capture ? '0 : cnt_q + 1'b1;
`endif
  end

  always_comb begin
    access = state_q == ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
    timeout = access && !mem_ack && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    timeout = 1'b0;
`endif
    stall     = access && !mem_ack && !timeout;
    mem_req   = access;
    mem_we    = access && dec_st;
    mem_addr  = access ? res_q : '0;
    mem_wdata = access ? sd_q : '0;
    rf_we     = valid_q && dec_wr && (!dec_ld || (access && mem_ack));
    rf_waddr  = rf_we ? dec_waddr : '0;
    rf_wdata  = rf_we ? (dec_ld ? mem_rdata : res_q) : '0;
    t_we      = valid_q && !tw_q && !stall;
    t_val     = t_we && t_q;
    bus_err   = timeout;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench with a memory responder and an instruction-class reference model
module tb_mem_wb_stage;
`ifdef MEM_TIMEOUT_EN
  localparam int MAXD = 3;
  localparam int TCYC = 4;
`else
  localparam int MAXD = 5;
  localparam int TCYC = 15;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 1'b0, ex_t_written = 1'b1, ex_t = 1'b0;
  logic [15:0] ex_res = '0, ex_store_data = '0, ex_instruction = '0;
  logic        stall, mem_req, mem_we, mem_ack, rf_we, t_we, t_val, bus_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_wdata;
  logic [3:0]  rf_waddr;

  mem_wb_stage #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_res(ex_res), .ex_store_data(ex_store_data),
    .ex_instruction(ex_instruction), .ex_t_written(ex_t_written), .ex_t(ex_t), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .t_we(t_we), .t_val(t_val), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [3:0] addr; logic [15:0] data;} rf_ev_t;
  typedef struct {int cyc; logic v;} t_ev_t;
  typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata; int delay;} mreq_t;
  rf_ev_t rfq[$];
  t_ev_t  tq[$];
  mreq_t  mq[$];
  int n_cmp = 0, n_bad = 0;
  int exp_err_cyc = -1;
  bit err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rf_ev_t e;
    t_ev_t  te;
    if (!rst) begin
      if (rf_we) begin
        if (rfq.size() == 0) chk("unexpected rf_we", 1, 0);
        else begin
          e = rfq.pop_front();
          chk("rf cycle", cyc, e.cyc);
          chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.addr});
          chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
        end
      end
      if (t_we) begin
        if (tq.size() == 0) chk("unexpected t_we", 1, 0);
        else begin
          te = tq.pop_front();
          chk("t cycle", cyc, te.cyc);
          chk("t_val", t_val, te.v);
        end
      end
      if (bus_err) begin
        err_seen = 1;
        chk("bus_err cycle", cyc, exp_err_cyc);
        chk("stall at bus_err", stall, 0);
      end
      if (stall) chk("stall without mem_req", mem_req, 1);
    end
  end

  initial begin
    mreq_t cur;
    bit busy = 0;
    int wn = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        mem_ack = 1'b0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          busy = 0;
        end
        if (busy && !mem_req) busy = 0;
        if (mem_req && !busy) begin
          busy = 1;
          if (mq.size() == 0) begin
            chk("unexpected mem_req", 1, 0);
            cur = '{1'b0, 16'h0, 16'h0, 16'h0, 1 << 20};
          end else cur = mq.pop_front();
          wn = cur.delay;
        end
        if (busy) begin
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, cur.addr});
          if (cur.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, cur.wdata});
          if (wn == 0) begin
            mem_ack = 1'b1;
            mem_rdata = cur.rdata;
          end else begin
            wn--;
            mem_rdata = 16'($urandom);
          end
        end
      end
    end
  end

  task automatic gen(input int k, output logic [15:0] ins, output int dest, output bit ld, output bit st);
    logic [2:0] a, b, c;
    logic [7:0] im;
    a = 3'($urandom); b = 3'($urandom); c = 3'($urandom); im = 8'($urandom);
    ld = 0; st = 0; dest = -1;
    case (k)
      0:  begin ins = {5'b01101, a, im};                dest = int'(a); end
      1:  begin ins = {5'b01000, a, b, 1'b0, im[3:0]};  dest = int'(b); end
      2:  begin ins = {5'b11100, a, b, c, 2'b01};       dest = int'(c); end
      3:  begin ins = {5'b01100, 3'b011, im};           dest = 8; end
      4:  begin ins = {5'b01100, 3'b100, a, 5'b00000};  dest = 8; end
      5:  begin ins = {5'b11110, a, 8'h00};             dest = int'(a); end
      6:  begin ins = {5'b11110, a, 8'h01};             dest = 9; end
      7:  begin ins = {5'b11101, a, b, 5'b01100};       dest = int'(a); end
      8:  ins = {5'b11101, a, b, 5'b01010};
      9:  ins = {5'b11101, a, 3'b000, 5'b00000};
      10: begin ins = {5'b11101, a, 3'b010, 5'b00000};  dest = int'(a); end
      11: ins = {5'b00010, im, 3'b000};
      12: begin ins = {5'b10011, a, b, im[4:0]};        dest = int'(b); ld = 1; end
      13: begin ins = {5'b10010, a, im};                dest = int'(a); ld = 1; end
      14: begin ins = {5'b11011, a, b, im[4:0]};        st = 1; end
      15: begin ins = {5'b11010, a, im};                st = 1; end
      16: begin ins = {5'b01111, a, b, 5'b00000};       dest = int'(a); end
      17: begin ins = {5'b00110, a, b, im[2:0], 2'b00}; dest = int'(a); end
      18: begin ins = {5'b01001, a, im};                dest = int'(a); end
      19: begin ins = {5'b00000, a, im};                dest = int'(a); end
      20: begin ins = {5'b11101, a, b, 5'b00110};       dest = int'(a); end
      default: ins = {5'b01100, 3'b000, im};
    endcase
  endtask

  task automatic issue_raw(input logic [15:0] ins, input logic [15:0] res, input logic [15:0] sd,
                           input logic tw, input logic t, input int dest, input bit ld, input bit st,
                           input int d, input logic [15:0] rd, input bit expect_wb,
                           output int n, output int c);
    logic s;
    int lat;
    ex_valid = 1'b1; ex_instruction = ins; ex_res = res; ex_store_data = sd;
    ex_t_written = tw; ex_t = t;
    if (ld || st) mq.push_back('{st, res, sd, rd, d});
    n = 0;
    do begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      n++;
    end while (s && n < 300);
    #1;
    c = cyc;
    ex_valid = 1'b0;
    if (s) chk("capture wait expired", 1, 0);
    else if (expect_wb) begin
      lat = (ld || st) ? d : 0;
      if (dest >= 0) rfq.push_back('{c + lat, 4'(dest), ld ? rd : res});
      if (!tw) tq.push_back('{c + lat, t});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c, dest;
    logic [15:0] ins;
    bit ld, st;
    logic tw;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset stall", stall, 0);
    chk("reset rf_we", rf_we, 0);
    chk("reset t_we", t_we, 0);
    chk("reset bus_err", bus_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue_raw(16'h6B5A, 16'h005A, 16'h0, 1, 0, 3, 0, 0, 0, 0, 1, n, c);
    chk("li stall", stall, 0);
    issue_raw(16'hE94A, 16'h1357, 16'h0, 0, 1, -1, 0, 0, 0, 0, 1, n, c);
    issue_raw(16'h9920, 16'h8000, 16'h1234, 1, 0, 1, 1, 0, 3, 16'hBEEF, 1, n, c);
    issue_raw(16'h6A11, 16'h0011, 16'h0, 1, 0, 2, 0, 0, 0, 0, 1, n, c);
    chk("lw stall cycles + capture", n, 4);
    issue_raw(16'hD920, 16'h0100, 16'hCAFE, 1, 0, -1, 0, 1, 0, 0, 1, n, c);
    issue_raw(16'h9920, 16'h0100, 16'h0, 1, 0, 1, 1, 0, 0, 16'hCAFE, 1, n, c);
    chk("back-to-back capture wait", n, 1);
    repeat (3) @(posedge clk);
    #1;
    issue_raw(16'h9920, 16'h2000, 16'h0, 1, 0, 1, 1, 0, 1000, 16'h0, 0, n, c);
    repeat (3) @(posedge clk);
    #1;
    chk("pending access stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst stall", stall, 0);
    chk("rst rf_we", rf_we, 0);
    chk("rst mem_addr", {16'd0, mem_addr}, 0);
    chk("rst rf_wdata", {16'd0, rf_wdata}, 0);
    chk("rst t_we", t_we, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`ifdef MEM_TIMEOUT_EN
    issue_raw(16'h9920, 16'h3000, 16'h0, 1, 0, 1, 1, 0, 1000, 16'h0, 0, n, c);
    exp_err_cyc = c + 3;
    repeat (6) @(posedge clk);
    #1;
    chk("bus_err seen", err_seen, 1);
    chk("mem_req dropped after abort", mem_req, 0);
    exp_err_cyc = -1;
`endif
    for (int i = 0; i < 300; i++) begin
      gen($urandom_range(0, 21), ins, dest, ld, st);
      tw = (ld || st) ? 1'b1 : 1'($urandom_range(0, 1));
      issue_raw(ins, 16'($urandom), 16'($urandom), tw, 1'($urandom), dest, ld, st,
                $urandom_range(0, MAXD), 16'($urandom), 1, n, c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("rf scoreboard drained", rfq.size(), 0);
    chk("t scoreboard drained", tq.size(), 0);
    chk("mem requests drained", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
